// File: rtl/step_run_pkg.sv
// step_run_pkg
// Shared definitions for the step/run processor clock controller.
// Holds the 2-bit FSM state codes (also driven out to the board LEDs)
// and the width of the issued-advance counter.
package step_run_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] STEP   = 2'b01;
    localparam logic [1:0] RUN    = 2'b10;
    localparam logic [1:0] HALTED = 2'b11;

    localparam int STEP_COUNT_W = 16;

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer
// Synchronises one raw active-low pushbutton into the clock domain,
// debounces it and emits a single-cycle pulse when the debounced level
// goes from released to pressed. Releases produce no pulse.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   btn_n  - raw pushbutton, low = pressed, asynchronous to clk
//   press  - one-cycle pulse per accepted press
module button_debouncer
    import step_run_pkg::*;
#(
    parameter int DEBOUNCE_MAX = 270000,
    parameter int DB_W         = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    logic            sync_meta;
    logic            sync_out;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    // Synchronisers and the debounced level reset to "released" so that a
    // button held through reset is seen as a fresh press once it settles.
    // The counter only runs while the synced input disagrees with the
    // accepted level; any agreement restarts the qualification window.
    // The press pulse is taken from the previous and current accepted
    // level, so it lands one cycle after the level flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
            stable    <= 1'b1;
            stable_d  <= 1'b1;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= btn_n;
            sync_out  <= sync_meta;
            stable_d  <= stable;
            press     <= stable_d & ~stable;
            if (sync_out == stable) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_MAX - 1)) begin
                stable <= sync_out;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_run_controller.sv
// step_run_controller
// Generates single-cycle processor advance pulses from two DE2
// pushbuttons: manual single-step or free-run at a divided rate, and
// stops advancing once the processor reports it has finished.
//
// Ports:
//   clk_27      - 27 MHz system clock
//   reset_n     - asynchronous active-low reset
//   step_btn_n  - raw step pushbutton, low = pressed
//   run_btn_n   - raw run/stop pushbutton, low = pressed
//   halt        - processor OperationFinished, synchronous to clk_27
//   proc_enable - one-cycle advance pulse to the processor
//   run_mode    - high while free-running
//   halted      - high while halted
//   state       - FSM state code for LEDs
//   step_count  - number of advance pulses issued (wraps)
module step_run_controller
    import step_run_pkg::*;
#(
    parameter int DEBOUNCE_MAX = 270000,
    parameter int DB_W         = 19,
    parameter int RUN_DIV      = 13500000,
    parameter int DIV_W        = 24
) (
    input  logic                    clk_27,
    input  logic                    reset_n,
    input  logic                    step_btn_n,
    input  logic                    run_btn_n,
    input  logic                    halt,
    output logic                    proc_enable,
    output logic                    run_mode,
    output logic                    halted,
    output logic [1:0]              state,
    output logic [STEP_COUNT_W-1:0] step_count
);

    logic             step_press;
    logic             run_press;
    logic [1:0]       next_state;
    logic             next_pulse;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] next_div;

    button_debouncer #(
        .DEBOUNCE_MAX (DEBOUNCE_MAX),
        .DB_W         (DB_W)
    ) u_step_db (
        .clk   (clk_27),
        .rst_n (reset_n),
        .btn_n (step_btn_n),
        .press (step_press)
    );

    button_debouncer #(
        .DEBOUNCE_MAX (DEBOUNCE_MAX),
        .DB_W         (DB_W)
    ) u_run_db (
        .clk   (clk_27),
        .rst_n (reset_n),
        .btn_n (run_btn_n),
        .press (run_press)
    );

    // Next-state and pulse decision. Checks within each state are ordered
    // by priority: halt beats any press, and run beats step in IDLE. The
    // divider rests at zero outside RUN so entering RUN always starts a
    // full period; a terminal count coinciding with halt or a run press
    // is dropped because those branches win.
    always_comb begin
        next_state = state;
        next_pulse = 1'b0;
        next_div   = '0;
        case (state)
            IDLE: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (run_press) begin
                    next_state = RUN;
                end else if (step_press) begin
                    next_state = STEP;
                    next_pulse = 1'b1;
                end
            end
            STEP: begin
                next_state = halt ? HALTED : IDLE;
            end
            RUN: begin
                if (halt) begin
                    next_state = HALTED;
                end else if (run_press) begin
                    next_state = IDLE;
                end else if (div == DIV_W'(RUN_DIV - 1)) begin
                    next_pulse = 1'b1;
                end else begin
                    next_div = div + 1'b1;
                end
            end
            HALTED: begin
                if ((run_press || step_press) && !halt) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // All visible outputs are registered from the next-state decision so
    // the processor sees a glitch-free enable exactly one cycle wide. The
    // counter steps on the same edge that raises proc_enable.
    always_ff @(posedge clk_27 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            div         <= '0;
            proc_enable <= 1'b0;
            run_mode    <= 1'b0;
            halted      <= 1'b0;
            step_count  <= '0;
        end else begin
            state       <= next_state;
            div         <= next_div;
            proc_enable <= next_pulse;
            run_mode    <= (next_state == RUN);
            halted      <= (next_state == HALTED);
            if (next_pulse) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_step_run_controller.sv
// tb_step_run_controller
// Self-checking bench for step_run_controller with a small debounce
// window and run divider. Directed scenarios and a randomized run are
// compared every cycle against a behavioural model of the controller.
module tb_step_run_controller;

    localparam int DEBOUNCE_MAX = 4;
    localparam int DB_W         = 3;
    localparam int RUN_DIV      = 5;
    localparam int DIV_W        = 3;

    logic        clk_27 = 1'b0;
    logic        reset_n;
    logic        step_btn_n;
    logic        run_btn_n;
    logic        halt;
    logic        proc_enable;
    logic        run_mode;
    logic        halted;
    logic [1:0]  state;
    logic [15:0] step_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_27 = ~clk_27;

    step_run_controller #(
        .DEBOUNCE_MAX (DEBOUNCE_MAX),
        .DB_W         (DB_W),
        .RUN_DIV      (RUN_DIV),
        .DIV_W        (DIV_W)
    ) dut (
        .clk_27      (clk_27),
        .reset_n     (reset_n),
        .step_btn_n  (step_btn_n),
        .run_btn_n   (run_btn_n),
        .halt        (halt),
        .proc_enable (proc_enable),
        .run_mode    (run_mode),
        .halted      (halted),
        .state       (state),
        .step_count  (step_count)
    );

    // Behavioural model: button levels are judged from a history of raw
    // samples (a change is accepted once the DEBOUNCE_MAX samples that
    // reached the synchroniser output all disagree with the accepted
    // level); the controller is described by mode and elapsed RUN ticks.
    typedef enum {M_IDLE, M_STEP, M_RUN, M_HALT} mode_t;

    mode_t       m_mode;
    int          m_ticks;
    int          m_count;
    bit          m_pulse;
    bit   [15:0] hist_s, hist_r;
    bit          lvl_s, lvl_r;
    bit   [1:0]  pev_s, pev_r;

    function automatic bit window_differs(bit [15:0] h, bit lvl);
        for (int i = 2; i < DEBOUNCE_MAX + 2; i++) begin
            if (h[i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [20:0] expected_vec();
        logic [1:0] code;
        case (m_mode)
            M_IDLE:  code = 2'b00;
            M_STEP:  code = 2'b01;
            M_RUN:   code = 2'b10;
            default: code = 2'b11;
        endcase
        return {code, m_mode == M_RUN, m_mode == M_HALT, m_pulse, m_count[15:0]};
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_ticks = 0;
        m_count = 0;
        m_pulse = 1'b0;
        hist_s  = '1;
        hist_r  = '1;
        lvl_s   = 1'b1;
        lvl_r   = 1'b1;
        pev_s   = '0;
        pev_r   = '0;
    endtask

    task automatic model_step();
        bit ps, pr, fs, fr;
        ps = pev_s[1];
        pr = pev_r[1];
        hist_s = {hist_s[14:0], step_btn_n};
        hist_r = {hist_r[14:0], run_btn_n};
        fs = window_differs(hist_s, lvl_s);
        fr = window_differs(hist_r, lvl_r);
        pev_s = {pev_s[0], fs && lvl_s};
        pev_r = {pev_r[0], fr && lvl_r};
        if (fs) lvl_s = ~lvl_s;
        if (fr) lvl_r = ~lvl_r;
        m_pulse = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (halt) m_mode = M_HALT;
                else if (pr) begin m_mode = M_RUN; m_ticks = 0; end
                else if (ps) begin m_mode = M_STEP; m_pulse = 1'b1; end
            end
            M_STEP: m_mode = halt ? M_HALT : M_IDLE;
            M_RUN: begin
                if (halt) m_mode = M_HALT;
                else if (pr) m_mode = M_IDLE;
                else begin
                    m_ticks++;
                    if (m_ticks % RUN_DIV == 0) m_pulse = 1'b1;
                end
            end
            default: if ((pr || ps) && !halt) m_mode = M_IDLE;
        endcase
        if (m_pulse) m_count = (m_count + 1) % 65536;
    endtask

    task automatic cycle();
        @(posedge clk_27);
        model_step();
        @(negedge clk_27);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; step_btn_n = 1'b1; run_btn_n = 1'b1; halt = 1'b0;
        repeat (3) @(negedge clk_27);
        model_reset();
        vectors++;
        if ({state, run_mode, halted, proc_enable, step_count} !== 21'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %h expected %h",
                     {state, run_mode, halted, proc_enable, step_count}, 21'd0);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL reset_idle i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
    endtask

    task automatic test_glitch();
        logic [0:15] pat;
        pat = 16'b0001111111111111;
        for (int i = 0; i < 16; i++) begin
            step_btn_n = pat[i];
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL glitch i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
        vectors++;
        if (step_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL glitch_count: got %0d expected 0", step_count);
        end
    endtask

    task automatic test_step_bounce();
        logic [0:20] pat;
        int pulses;
        pulses = 0;
        pat = 21'b010000000000011111111;
        for (int i = 0; i < 21; i++) begin
            step_btn_n = pat[i];
            cycle();
            pulses += int'(proc_enable);
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL step_bounce i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
        vectors++;
        if (pulses != 1 || step_count !== 16'd1 || state !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL step_once: got pulses=%0d count=%0d state=%b expected 1 1 00",
                     pulses, step_count, state);
        end
    endtask

    task automatic test_run();
        int entry;
        int base;
        logic [15:0] snap;
        entry = -1; base = 0; snap = '0;
        for (int i = 0; i < 51; i++) begin
            run_btn_n = !((i < 7) || (i >= 30 && i < 37));
            cycle();
            if (entry < 0 && state == 2'b10) begin
                entry = i;
                base = int'(step_count);
            end
            if (i == 38) snap = step_count;
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL run i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
            if (entry >= 0 && i == entry + 20) begin
                vectors++;
                if (int'(step_count) != base + 4) begin
                    miscompares++;
                    $display("[TB] FAIL run_rate: got %0d expected %0d", step_count, base + 4);
                end
            end
        end
        vectors++;
        if (entry < 0 || state !== 2'b00 || step_count !== snap) begin
            miscompares++;
            $display("[TB] FAIL run_stop: got entry=%0d state=%b count=%0d expected state 00 count %0d",
                     entry, state, step_count, snap);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 60; i++) begin
            run_btn_n  = !(i < 6);
            halt       = (i >= 15 && i < 36);
            step_btn_n = !((i >= 20 && i < 28) || (i >= 40 && i < 48));
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL halt i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
            if (i == 15 || i == 46) begin
                vectors++;
                if (state !== 2'b11 || halted !== 1'b1 || proc_enable !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL halt_hold i=%0d: got state=%b halted=%b en=%b expected 11 1 0",
                             i, state, halted, proc_enable);
                end
            end
        end
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL halt_exit: got %b expected 00", state);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            step_btn_n = !(i < 6);
            run_btn_n  = !((i < 6) || (i >= 20 && i < 26));
            cycle();
            if (i <= 10) pulses += int'(proc_enable);
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL simul i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
            if (i == 10) begin
                vectors++;
                if (state !== 2'b10 || pulses != 0) begin
                    miscompares++;
                    $display("[TB] FAIL simul_run_wins: got state=%b pulses=%0d expected 10 0",
                             state, pulses);
                end
            end
        end
    endtask

    task automatic test_wrap();
        force dut.step_count = 16'hFFFF;
        m_count = 16'hFFFF;
        cycle();
        release dut.step_count;
        for (int i = 0; i < 16; i++) begin
            step_btn_n = !(i < 6);
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL wrap i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
        vectors++;
        if (step_count !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %h expected 0000", step_count);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 20; i++) begin
            run_btn_n  = !(i < 6);
            step_btn_n = !(i >= 12);
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL midrun i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({state, run_mode, halted, proc_enable, step_count} !== 21'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h expected %h",
                     {state, run_mode, halted, proc_enable, step_count}, 21'd0);
        end
        repeat (2) @(negedge clk_27);
        model_reset();
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step_btn_n = !(i < 10);
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL held_press i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
        vectors++;
        if (step_count !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL held_press_count: got %0d expected 1", step_count);
        end
    endtask

    task automatic test_random();
        int hold_s;
        int hold_r;
        hold_s = 0;
        hold_r = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold_s == 0) begin
                step_btn_n = 1'($urandom_range(0, 1));
                hold_s = int'($urandom_range(1, 12));
            end
            if (hold_r == 0) begin
                run_btn_n = 1'($urandom_range(0, 1));
                hold_r = int'($urandom_range(1, 14));
            end
            hold_s--;
            hold_r--;
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            cycle();
            vectors++;
            if ({state, run_mode, halted, proc_enable, step_count} !== expected_vec()) begin
                miscompares++;
                $display("[TB] FAIL random i=%0d: got %h expected %h", i,
                         {state, run_mode, halted, proc_enable, step_count}, expected_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_step_bounce();
        test_run();
        test_halt();
        test_simultaneous();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
